// File: rtl/ui_pkg.sv
// Shared UI definitions: button indices, per-button FSM states and
// default 100 MHz timing constants for the button conditioning logic.
package ui_pkg;

  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_C = 4;

  localparam int unsigned DEF_NUM_BTN         = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 200_000;     // 2 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 15_000_000;  // 150 ms
  localparam logic [4:0]  DEF_REPEAT_MASK     = 5'b01111;    // C does not repeat

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce counter and press/auto-repeat
// FSM producing registered single-cycle pulses.
module btn_channel
  import ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic held
);

  localparam int unsigned     DB_W         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0]     DELAY_LAST   = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]     PERIOD_LAST  = 32'(REPEAT_PERIOD - 1);

  logic            sync_q1;
  logic            sync_q2;
  logic [DB_W-1:0] db_cnt;
  logic            accept;
  logic            level_rise;
  logic            level_fall;

  btn_state_e  state_q, state_d;
  logic [31:0] rpt_cnt_q, rpt_cnt_d, rpt_cnt_inc;
  logic        pulse_d;

  // Level change is accepted on the edge where the counter has seen enough
  // stable mismatching cycles; rise/fall are decoded from that same event so
  // the FSM reacts on the edge btn_level itself changes.
  assign accept     = (sync_q2 != level) && (db_cnt == DB_LAST);
  assign level_rise = accept && !level;
  assign level_fall = accept && level;
  assign rpt_cnt_inc = (rpt_cnt_q == '1) ? rpt_cnt_q : rpt_cnt_q + 32'd1;
  assign held        = (state_q == REPEATING);

  // Two-flop synchroniser for the asynchronous raw level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce: count consecutive mismatching cycles, toggle level when stable
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_q2 == level) begin
      db_cnt <= '0;
    end else if (accept) begin
      db_cnt <= '0;
      level  <= ~level;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // FSM state, repeat counter and registered pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      pulse     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse     <= pulse_d;
    end
  end

  // Next-state: a release always wins over a due repeat pulse
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_inc;
    pulse_d   = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_cnt_d = '0;
        if (level_rise) begin
          pulse_d = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (level_fall) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (REPEAT_EN && rpt_cnt_q == DELAY_LAST) begin
          pulse_d   = 1'b1;
          rpt_cnt_d = '0;
          state_d   = REPEATING;
        end
      end
      REPEATING: begin
        if (level_fall) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == PERIOD_LAST) begin
          pulse_d   = 1'b1;
          rpt_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Conditions raw push-buttons into debounced levels and single-cycle
// press/repeat pulses; optionally suppresses coincident L/R pulses.
module btn_pulse_gen
  import ui_pkg::*;
#(
  parameter int unsigned          NUM_BTN         = DEF_NUM_BTN,
  parameter int unsigned          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned          REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned          REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0]   REPEAT_MASK     = DEF_REPEAT_MASK,
  parameter bit                   LR_EXCLUSIVE    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_held
);

  logic [NUM_BTN-1:0] ch_pulse;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .pulse (ch_pulse[i]),
      .held  (btn_held[i])
    );
  end

  if (LR_EXCLUSIVE && NUM_BTN > BTN_R) begin : g_lr
    // Coincident L and R moves are ambiguous: drop both, FSMs run on
    always_comb begin
      btn_pulse = ch_pulse;
      if (ch_pulse[BTN_L] && ch_pulse[BTN_R]) begin
        btn_pulse[BTN_L] = 1'b0;
        btn_pulse[BTN_R] = 1'b0;
      end
    end
  end else begin : g_pass
    assign btn_pulse = ch_pulse;
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen: two instances (L/R exclusive on and off)
// share the stimulus; pulses are checked against a scoreboard queue of
// expected (cycle, vector) entries, levels/held by direct checks.
module tb_btn_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] lvl_x, pulse_x, held_x;
  logic [4:0] lvl_nx, pulse_nx, held_nx;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [9:0] vec;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_pulse_gen #(
    .NUM_BTN         (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .REPEAT_MASK     (5'b01111),
    .LR_EXCLUSIVE    (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (lvl_x),
    .btn_pulse (pulse_x),
    .btn_held  (held_x)
  );

  btn_pulse_gen #(
    .NUM_BTN         (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8),
    .REPEAT_MASK     (5'b01111),
    .LR_EXCLUSIVE    (1'b0)
  ) dut_nx (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (lvl_nx),
    .btn_pulse (pulse_nx),
    .btn_held  (held_nx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic goto(input int m);
    while (cyc < m) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_pulse(input int c, input logic [4:0] vx, input logic [4:0] vnx);
    exp_t e;
    e.cyc = c;
    e.vec = {vx, vnx};
    exp_q.push_back(e);
  endtask

  // Scoreboard: every pulse seen must be the next expected entry at its cycle
  always @(negedge clk) begin
    logic [9:0] obs;
    exp_t       e;
    obs = {pulse_x, pulse_nx};
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check($sformatf("pulse_at_%0d", e.cyc), 32'(obs), 32'(e.vec));
    end else if (obs !== '0) begin
      check("unexpected_pulse", 32'(obs), 32'd0);
    end
  end

  initial begin
    reset   = 1'b1;
    btn_raw = '0;

    // Reset state
    goto(2);
    check("rst_level", 32'(lvl_x), 32'd0);
    check("rst_held",  32'(held_x), 32'd0);
    check("rst_pulse", 32'(pulse_x), 32'd0);
    goto(3);
    reset = 1'b0;

    // Clean press of R at 10, held 10 cycles
    goto(10);
    btn_raw[1] = 1'b1;
    expect_pulse(16, 5'b00010, 5'b00010);
    goto(15);
    check("r_level_before", 32'(lvl_x[1]), 32'd0);
    goto(16);
    check("r_level_rise", 32'(lvl_x[1]), 32'd1);
    goto(20);
    btn_raw[1] = 1'b0;
    goto(21);
    check("r_held", 32'(held_x[1]), 32'd0);
    goto(26);
    check("r_level_fall", 32'(lvl_x[1]), 32'd0);

    // Bouncing press on L: 1,0,1,1,0 then steady 1 from cycle 35
    goto(30); btn_raw[0] = 1'b1;
    goto(31); btn_raw[0] = 1'b0;
    goto(32); btn_raw[0] = 1'b1;
    goto(34); btn_raw[0] = 1'b0;
    goto(35); btn_raw[0] = 1'b1;
    expect_pulse(41, 5'b00001, 5'b00001);
    goto(40);
    check("l_bounce_level_before", 32'(lvl_x[0]), 32'd0);
    goto(41);
    check("l_bounce_level_rise", 32'(lvl_x[0]), 32'd1);
    goto(45);
    btn_raw[0] = 1'b0;
    goto(51);
    check("l_level_fall", 32'(lvl_x[0]), 32'd0);

    // Hold D: level high 66..125, release lands on a due repeat (dropped)
    goto(60);
    btn_raw[3] = 1'b1;
    expect_pulse(66,  5'b01000, 5'b01000);
    expect_pulse(86,  5'b01000, 5'b01000);
    expect_pulse(94,  5'b01000, 5'b01000);
    expect_pulse(102, 5'b01000, 5'b01000);
    expect_pulse(110, 5'b01000, 5'b01000);
    expect_pulse(118, 5'b01000, 5'b01000);
    goto(85);
    check("d_held_before", 32'(held_x[3]), 32'd0);
    goto(86);
    check("d_held_rise", 32'(held_x[3]), 32'd1);
    check("d_held_rise_nx", 32'(held_nx[3]), 32'd1);
    goto(120);
    btn_raw[3] = 1'b0;
    goto(125);
    check("d_held_last", 32'(held_x[3]), 32'd1);
    goto(126);
    check("d_held_fall", 32'(held_x[3]), 32'd0);
    check("d_level_fall", 32'(lvl_x[3]), 32'd0);

    // Hold C for 100 cycles: single pulse, never held
    goto(140);
    btn_raw[4] = 1'b1;
    expect_pulse(146, 5'b10000, 5'b10000);
    goto(166);
    check("c_held_delay", 32'(held_x[4]), 32'd0);
    goto(200);
    check("c_held_mid", 32'(held_x[4]), 32'd0);
    goto(239);
    check("c_level_high", 32'(lvl_x[4]), 32'd1);
    goto(240);
    btn_raw[4] = 1'b0;
    goto(246);
    check("c_level_fall", 32'(lvl_x[4]), 32'd0);

    // L and R together: suppressed when exclusive, both pulse otherwise
    goto(260);
    btn_raw[1:0] = 2'b11;
    expect_pulse(266, 5'b00000, 5'b00011);
    goto(266);
    check("lr_level", 32'(lvl_x[1:0]), 32'd3);
    check("lr_level_nx", 32'(lvl_nx[1:0]), 32'd3);
    goto(270);
    btn_raw[1:0] = 2'b00;
    goto(276);
    check("lr_level_fall", 32'(lvl_x[1:0]), 32'd0);

    // Reset while U is repeating, button kept held throughout
    goto(290);
    btn_raw[2] = 1'b1;
    expect_pulse(296, 5'b00100, 5'b00100);
    expect_pulse(316, 5'b00100, 5'b00100);
    expect_pulse(324, 5'b00100, 5'b00100);
    goto(325);
    check("u_held_pre_reset", 32'(held_x[2]), 32'd1);
    goto(326);
    reset = 1'b1;
    goto(327);
    check("mid_rst_level", 32'(lvl_x), 32'd0);
    check("mid_rst_held",  32'(held_x), 32'd0);
    check("mid_rst_pulse", 32'({pulse_x, pulse_nx}), 32'd0);
    goto(329);
    reset = 1'b0;
    expect_pulse(335, 5'b00100, 5'b00100);
    expect_pulse(355, 5'b00100, 5'b00100);
    expect_pulse(363, 5'b00100, 5'b00100);
    goto(334);
    check("u_level_after_rst", 32'(lvl_x[2]), 32'd0);
    goto(335);
    check("u_level_reaccept", 32'(lvl_x[2]), 32'd1);
    goto(354);
    check("u_held_before", 32'(held_x[2]), 32'd0);
    goto(355);
    check("u_held_rise", 32'(held_x[2]), 32'd1);
    goto(365);
    btn_raw[2] = 1'b0;
    goto(371);
    check("u_held_fall", 32'(held_x[2]), 32'd0);

    goto(390);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Conditions the raw Basys push-buttons into clean single-cycle move/select pulses for the cursor and menu drawing blocks on the 96x64 OLED.
- Each button is synchronised, debounced and edge-detected. Held buttons can auto-repeat.
- Its outputs feed the btnL/btnR-style inputs of the drawing logic. Those consumers then only ever see one-clock-wide pulses in the system clock domain.

Parameters:
- NUM_BTN, 5, number of buttons; bit order 0=L, 1=R, 2=U, 3=D, 4=C.
- DEBOUNCE_CYCLES, 200000, consecutive stable cycles needed to accept a level change (2 ms at 100 MHz).
- REPEAT_DELAY, 50000000, held cycles after the first pulse before the first repeat pulse.
- REPEAT_PERIOD, 15000000, cycles between subsequent repeat pulses.
- REPEAT_MASK, 5'b01111, per-button auto-repeat enable (C does not repeat).
- LR_EXCLUSIVE, 1, when 1, simultaneous L and R pulses in the same cycle are both suppressed.

Ports:
- clk, in, 1, system clock (100 MHz).
- reset, in, 1, synchronous active-high reset.
- btn_raw, in, NUM_BTN, asynchronous raw button levels.
- btn_level, out, NUM_BTN, debounced button level.
- btn_pulse, out, NUM_BTN, one-cycle pulse per accepted press or repeat.
- btn_held, out, NUM_BTN, 1 while the button is in the REPEATING state.

Behaviour:
- Reset: all synchroniser flops, btn_level, btn_pulse, btn_held and all counters are 0; every per-button FSM is IDLE. Reset mid-press discards any pending debounce or repeat. A button still held when reset deasserts is re-accepted only after a full DEBOUNCE_CYCLES.
- Synchroniser: two flops per bit; sync = second flop.
- Debounce counter: per bit, width clog2(DEBOUNCE_CYCLES+1).
  - If sync == btn_level, the counter clears.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1, btn_level toggles on the next edge and the counter clears.
  - Any glitch back to the old level before then clears the counter, so no toggle occurs.
- Latency: a clean raw transition reaches btn_level after 2 + DEBOUNCE_CYCLES clocks.
- Per-button FSM and shared repeat counter. The counter is 32-bit, one per button, saturating, and never wraps.
  - IDLE: on a btn_level rising edge, assert btn_pulse in the same cycle btn_level first reads 1. Clear the counter. Go to WAIT.
  - WAIT: count up. If btn_level falls, go to IDLE with no pulse. If the count reaches REPEAT_DELAY-1 with REPEAT_MASK[i]=1, pulse, clear the count and go to REPEATING. With REPEAT_MASK[i]=0, stay in WAIT until release.
  - REPEATING: btn_held=1. Pulse every REPEAT_PERIOD cycles. On a btn_level fall, go to IDLE immediately; any pending pulse is dropped.
- Release never generates a pulse.
- btn_pulse is registered and is never high for two consecutive cycles for the same bit (requires REPEAT_PERIOD >= 2).
- Simultaneous events:
  - Different buttons are fully independent.
  - If LR_EXCLUSIVE=1 and the raw pulses on bit0 and bit1 coincide, both outputs stay 0 that cycle. FSM state still advances as normal.

Decomposition:
- Shared package (ui_pkg): button index constants BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3, BTN_C=4; FSM state encoding IDLE=2'd0, WAIT=2'd1, REPEATING=2'd2; default timing constants for 100 MHz.
- Sub-module btn_channel holds one button's sync, debounce and FSM, and is instantiated NUM_BTN times by a generate loop.
- The top level adds only the LR_EXCLUSIVE masking.

Test Plan (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, NUM_BTN=5):
- Clean press of bit1 at cycle 10, held 10 cycles -> btn_level[1] rises at cycle 16; exactly one btn_pulse[1] at cycle 16; no pulse on release; btn_held stays 0.
- Bouncing press on bit0: 1,0,1,1,0 then steady 1 -> no pulse or level change until 4 stable cycles; then exactly one pulse.
- Hold bit3 for 60 cycles after acceptance -> pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52; btn_held[3]=1 from t0+20; release -> btn_held falls, no further pulse.
- Hold bit4 (C, non-repeating) for 100 cycles -> exactly one pulse; btn_held[4] never asserts.
- Press bit0 and bit1 on the same raw cycle -> both levels rise together, btn_pulse[1:0]=00. Repeat with LR_EXCLUSIVE=0 -> btn_pulse[1:0]=11 for one cycle.
- Assert reset while bit2 is in REPEATING, keep the button held -> all outputs 0 during reset; after release of reset, first pulse arrives 2+4 cycles later, then the repeat schedule restarts from REPEAT_DELAY.
